alu: RTL and testbench

Registered 8-bit arithmetic/logic unit. Computes one result byte and four status flags from two operands and an opcode on every clock edge. Sits as the execution stage of the datapath, fed directly by operand and opcode registers. Outputs are valid one cycle after the inputs are sampled.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 81 ++++++++
 rtl/alu.sv | 37 +++
 tb/tb_alu.sv | 101 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the registered ALU.
package alu_pkg;

  localparam logic [7:0] OP_ADD   = 8'h00;
  localparam logic [7:0] OP_SUB   = 8'h01;
  localparam logic [7:0] OP_AND   = 8'h02;
  localparam logic [7:0] OP_OR    = 8'h03;
  localparam logic [7:0] OP_XOR   = 8'h04;
  localparam logic [7:0] OP_NOT   = 8'h05;
  localparam logic [7:0] OP_SHL   = 8'h06;
  localparam logic [7:0] OP_SHR   = 8'h07;
  localparam logic [7:0] OP_ASR   = 8'h08;
  localparam logic [7:0] OP_ROL   = 8'h09;
  localparam logic [7:0] OP_ROR   = 8'h0A;
  localparam logic [7:0] OP_INC   = 8'h0B;
  localparam logic [7:0] OP_DEC   = 8'h0C;
  localparam logic [7:0] OP_MUL   = 8'h0D;
  localparam logic [7:0] OP_CMP   = 8'h0E;
  localparam logic [7:0] OP_PASSB = 8'h0F;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: next result, next flags and a hold request for CMP.
module alu_core
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] op,
  output logic [7:0] next_c,
  output logic [3:0] next_flags,
  output logic       hold_c
);

  logic [2:0]  sh;
  logic [7:0]  rhs;
  logic [8:0]  add_w;
  logic [8:0]  sub_w;
  logic [8:0]  shl_w;
  logic [8:0]  shr_w;
  logic [8:0]  asr_w;
  logic [7:0]  rol_r;
  logic [7:0]  ror_r;
  logic [15:0] prod;
  logic        add_v;
  logic        sub_v;

  assign sh  = b[2:0];
  // INC/DEC reuse the add/sub paths with an implied operand of one
  assign rhs = (op == OP_INC || op == OP_DEC) ? 8'h01 : b;

  assign add_w = {1'b0, a} + {1'b0, rhs};
  assign sub_w = {1'b0, a} - {1'b0, rhs};
  assign add_v = (a[7] == rhs[7]) && (add_w[7] != a[7]);
  assign sub_v = (a[7] != rhs[7]) && (sub_w[7] != a[7]);

  // Extra bit beside the operand catches the last bit shifted out; zero for amount 0
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;
  assign asr_w = $signed({a, 1'b0}) >>> sh;
  assign rol_r = (a << sh) | (a >> (4'd8 - {1'b0, sh}));
  assign ror_r = (a >> sh) | (a << (4'd8 - {1'b0, sh}));
  assign prod  = a * b;

  always_comb begin
    logic       valid;
    logic       cy;
    logic       ov;
    logic [7:0] res;
    valid  = 1'b1;
    cy     = 1'b0;
    ov     = 1'b0;
    res    = 8'h00;
    hold_c = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin res = add_w[7:0]; cy = add_w[8]; ov = add_v; end
      OP_SUB, OP_DEC: begin res = sub_w[7:0]; cy = sub_w[8]; ov = sub_v; end
      OP_CMP:         begin res = sub_w[7:0]; cy = sub_w[8]; ov = sub_v; hold_c = 1'b1; end
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NOT:   res = ~a;
      OP_SHL:   begin res = shl_w[7:0]; cy = shl_w[8]; end
      OP_SHR:   begin res = shr_w[8:1]; cy = shr_w[0]; end
      OP_ASR:   begin res = asr_w[8:1]; cy = asr_w[0]; end
      OP_ROL:   res = rol_r;
      OP_ROR:   res = ror_r;
      OP_MUL:   begin res = prod[7:0]; cy = (prod[15:8] != 8'h00); end
      OP_PASSB: res = b;
      default:  valid = 1'b0;
    endcase

    next_c     = valid ? res : 8'h00;
    next_flags = 4'b0000;
    if (valid) begin
      next_flags[FLAG_C] = cy;
      next_flags[FLAG_Z] = (res == 8'h00);
      next_flags[FLAG_N] = res[7];
      next_flags[FLAG_V] = ov;
    end
  end

endmodule

// File: rtl/alu.sv
// Registered ALU stage: result and flags are captured one cycle after operands.
module alu
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] op,
  output logic [7:0] c,
  output logic [3:0] flags
);

  logic [7:0] next_c;
  logic [3:0] next_flags;
  logic       hold_c;

  alu_core u_core (
    .a          (a),
    .b          (b),
    .op         (op),
    .next_c     (next_c),
    .next_flags (next_flags),
    .hold_c     (hold_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      c     <= 8'h00;
      flags <= 4'b0000;
    end else begin
      if (!hold_c) c <= next_c;
      flags <= next_flags;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU with immediate-assertion checks.
module tb_alu;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] op;
  logic [7:0] c;
  logic [3:0] flags;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .op    (op),
    .c     (c),
    .flags (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp_c, input logic [3:0] exp_f);
    checks++;
    assert (c === exp_c) else begin
      errors++;
      $error("FAIL %s c: got %h expected %h", tag, c, exp_c);
    end
    checks++;
    assert (flags === exp_f) else begin
      errors++;
      $error("FAIL %s flags: got %b expected %b", tag, flags, exp_f);
    end
  endtask

  task automatic step(input logic [7:0] na, input logic [7:0] nb, input logic [7:0] nop);
    a  = na;
    b  = nb;
    op = nop;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a = 8'hFF; b = 8'h01; op = 8'h00;
    @(posedge clk); #1;
    check("reset1", 8'h00, 4'b0000);
    @(posedge clk); #1;
    check("reset2", 8'h00, 4'b0000);
    reset = 1'b0;
    @(posedge clk); #1;
    check("add_ff_01", 8'h00, 4'b1100);

    step(8'h7F, 8'h01, 8'h00); check("add_ovf",   8'h80, 4'b0011);
    step(8'h80, 8'h01, 8'h01); check("sub_ovf",   8'h7F, 4'b0001);
    step(8'h00, 8'h55, 8'h0F); check("passb",     8'h55, 4'b0000);
    step(8'h10, 8'h20, 8'h0E); check("cmp_lt",    8'h55, 4'b1010);
    step(8'h20, 8'h20, 8'h0E); check("cmp_eq",    8'h55, 4'b0100);
    step(8'h81, 8'h01, 8'h06); check("shl1",      8'h02, 4'b1000);
    step(8'h80, 8'h03, 8'h08); check("asr3",      8'hF0, 4'b0010);
    step(8'h01, 8'h01, 8'h0A); check("ror1",      8'h80, 4'b0010);
    step(8'h5A, 8'h00, 8'h06); check("shl0",      8'h5A, 4'b0000);
    step(8'h81, 8'h08, 8'h06); check("shl_b8",    8'h81, 4'b0010);
    step(8'h81, 8'h01, 8'h07); check("shr1",      8'h40, 4'b1000);
    step(8'h81, 8'h01, 8'h09); check("rol1",      8'h03, 4'b0000);
    step(8'h10, 8'h10, 8'h0D); check("mul_hi",    8'h00, 4'b1100);
    step(8'h0F, 8'h11, 8'h0D); check("mul_lo",    8'hFF, 4'b0010);
    step(8'hF0, 8'h0F, 8'h02); check("and",       8'h00, 4'b0100);
    step(8'hF0, 8'h0F, 8'h03); check("or",        8'hFF, 4'b0010);
    step(8'hFF, 8'hFF, 8'h04); check("xor",       8'h00, 4'b0100);
    step(8'h00, 8'h00, 8'h05); check("not",       8'hFF, 4'b0010);
    step(8'hFF, 8'h00, 8'h0B); check("inc_ff",    8'h00, 4'b1100);
    step(8'h7F, 8'h00, 8'h0B); check("inc_7f",    8'h80, 4'b0011);
    step(8'h00, 8'h00, 8'h0C); check("dec_00",    8'hFF, 4'b1010);
    step(8'h80, 8'h00, 8'h0C); check("dec_80",    8'h7F, 4'b0001);
    step(8'h12, 8'h34, 8'h42); check("illegal42", 8'h00, 4'b0000);
    step(8'hFF, 8'hFF, 8'h10); check("illegal10", 8'h00, 4'b0000);

    // Latency: new inputs must not show before the edge
    a = 8'h01; b = 8'h01; op = 8'h00;
    #2;
    check("pre_edge", 8'h00, 4'b0000);
    @(posedge clk); #1;
    check("post_edge", 8'h02, 4'b0000);

    reset = 1'b1;
    step(8'h7F, 8'h01, 8'h00); check("mid_reset", 8'h00, 4'b0000);
    reset = 1'b0;
    step(8'h7F, 8'h01, 8'h00); check("after_rst", 8'h80, 4'b0011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
